// File: rtl/lc3b_mem_responder_pkg.sv
// ---------------------------------------------------------------------------
// lc3b_types
//   Shared LC-3b types for the memory interface: the 16-bit machine word,
//   the two-lane byte enable and the responder FSM state encoding.
// ---------------------------------------------------------------------------
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_be;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_BUSY,
    MEM_RESP
  } lc3b_mem_state;

  // Latency counter width; supports latencies 1..15.
  localparam int unsigned LC3B_MEM_CNT_W = 4;

endpackage

// File: rtl/lc3b_mem_responder_mem_array_2byte.sv
// ---------------------------------------------------------------------------
// mem_array_2byte
//   2^DEPTH_LOG2 x 16-bit storage with a registered read port and a
//   per-byte-lane synchronous write port. Contents are never reset.
//
// Ports
//   clk       in   clock, rising edge
//   rd_en     in   capture mem[rd_index] into rd_data on the next edge
//   rd_index  in   read word index
//   rd_data   out  registered read data, holds until the next rd_en
//   wr_en     in   write strobe
//   wr_be     in   lane enables: [1]=bits 15:8, [0]=bits 7:0
//   wr_index  in   write word index
//   wr_data   in   write data
// ---------------------------------------------------------------------------
module mem_array_2byte
  import lc3b_types::*;
#(
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  rd_en,
  input  logic [DEPTH_LOG2-1:0] rd_index,
  output lc3b_word              rd_data,
  input  logic                  wr_en,
  input  lc3b_mem_be            wr_be,
  input  logic [DEPTH_LOG2-1:0] wr_index,
  input  lc3b_word              wr_data
);

  lc3b_word mem [0:(1 << DEPTH_LOG2)-1];
  lc3b_word rd_data_q;
  lc3b_word rd_data_d;

  // Read register only moves when a read is requested, so the last read
  // value stays visible for as long as the caller needs it.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem[rd_index];
    end
  end

  always_ff @(posedge clk) begin
    rd_data_q <= rd_data_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_be[0]) begin
        mem[wr_index][7:0] <= wr_data[7:0];
      end
      if (wr_be[1]) begin
        mem[wr_index][15:8] <= wr_data[15:8];
      end
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/lc3b_mem_responder.sv
// ---------------------------------------------------------------------------
// lc3b_mem_responder
//   Memory-side responder for the LC-3b memory interface. A read or write
//   request is latched in IDLE, serviced from an internal word array after
//   LATENCY cycles, and acknowledged with a one-cycle mem_resp pulse.
//
// Parameters
//   DEPTH_LOG2  log2 of array depth in 16-bit words
//   LATENCY     cycles from request sample to mem_resp (1..15)
//
// Ports
//   clk              in   clock, rising edge
//   reset            in   synchronous, active-high reset
//   mem_read         in   read request, held until mem_resp
//   mem_write        in   write request, held until mem_resp
//   mem_byte_enable  in   write lanes: [1]=bits 15:8, [0]=bits 7:0
//   mem_address      in   byte address
//   mem_wdata        in   write data
//   mem_resp         out  one-cycle completion pulse
//   mem_rdata        out  read data, valid in the mem_resp cycle
//   proto_err        out  sticky protocol-violation flag
//
// Configuration
//   LC3B_MEM_PROTO_CHECK_EN  when defined, a protocol checker drives
//                            proto_err; otherwise proto_err is 1'b0.
// ---------------------------------------------------------------------------
module lc3b_mem_responder
  import lc3b_types::*;
#(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned LATENCY    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mem_read,
  input  logic       mem_write,
  input  lc3b_mem_be mem_byte_enable,
  input  lc3b_word   mem_address,
  input  lc3b_word   mem_wdata,
  output logic       mem_resp,
  output lc3b_word   mem_rdata,
  output logic       proto_err
);

  localparam logic [LC3B_MEM_CNT_W-1:0] LAT_M1 = LC3B_MEM_CNT_W'(LATENCY - 1);

  lc3b_mem_state               state_q, state_d;
  logic [LC3B_MEM_CNT_W-1:0]   cnt_q, cnt_d;
  lc3b_word                    addr_q, addr_d;
  lc3b_word                    wdata_q, wdata_d;
  lc3b_mem_be                  be_q, be_d;
  logic                        rd_q, rd_d;
  logic                        wr_q, wr_d;
  logic                        rdata_zero_q, rdata_zero_d;

  logic                        req;
  logic                        arr_rd;
  logic                        arr_rd_en;
  logic                        arr_wr_en;
  logic [DEPTH_LOG2-1:0]       rd_index;
  lc3b_word                    arr_rdata;

  assign req = mem_read | mem_write;

  // Next-state logic. The array read is launched on the edge that enters
  // RESP so the data lands in the RESP cycle; a write commits on the edge
  // leaving RESP, which makes a combined read+write naturally return the
  // pre-write contents. With LATENCY==1 IDLE jumps straight to RESP, so the
  // read must use the live address rather than the not-yet-latched copy.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    arr_rd       = 1'b0;
    rd_index     = addr_q[DEPTH_LOG2:1];

    case (state_q)
      MEM_IDLE: begin
        if (req) begin
          addr_d  = mem_address;
          wdata_d = mem_wdata;
          be_d    = mem_byte_enable;
          rd_d    = mem_read;
          wr_d    = mem_write;
          cnt_d   = LAT_M1;
          if (LATENCY == 1) begin
            state_d  = MEM_RESP;
            arr_rd   = mem_read;
            rd_index = mem_address[DEPTH_LOG2:1];
          end else begin
            state_d = MEM_BUSY;
          end
        end
      end
      MEM_BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == LC3B_MEM_CNT_W'(1)) begin
          state_d = MEM_RESP;
          arr_rd  = rd_q;
        end
      end
      MEM_RESP: begin
        state_d = MEM_IDLE;
      end
      default: begin
        state_d = MEM_IDLE;
      end
    endcase
  end

  // mem_rdata reads as zero after reset until the first read completes;
  // the array's read register itself cannot be reset.
  always_comb begin
    rdata_zero_d = rdata_zero_q;
    if (arr_rd_en) begin
      rdata_zero_d = 1'b0;
    end
  end

  assign arr_rd_en = arr_rd & ~reset;
  assign arr_wr_en = (state_q == MEM_RESP) & wr_q & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= MEM_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      rdata_zero_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      rdata_zero_q <= rdata_zero_d;
    end
  end

  mem_array_2byte #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk      (clk),
    .rd_en    (arr_rd_en),
    .rd_index (rd_index),
    .rd_data  (arr_rdata),
    .wr_en    (arr_wr_en),
    .wr_be    (be_q),
    .wr_index (addr_q[DEPTH_LOG2:1]),
    .wr_data  (wdata_q)
  );

  assign mem_resp  = (state_q == MEM_RESP);
  assign mem_rdata = rdata_zero_q ? 16'h0000 : arr_rdata;

`ifdef LC3B_MEM_PROTO_CHECK_EN
  logic proto_err_q, proto_err_d;
  logic violation;

  // While a transaction is in flight the initiator must hold the exact
  // request it issued; a combined read+write request is also flagged.
  always_comb begin
    violation = 1'b0;
    if ((state_q == MEM_BUSY) || (state_q == MEM_RESP)) begin
      if (!req || (mem_address != addr_q) || (mem_wdata != wdata_q) ||
          (mem_byte_enable != be_q) || (mem_read != rd_q) ||
          (mem_write != wr_q)) begin
        violation = 1'b1;
      end
    end else if (mem_read && mem_write) begin
      violation = 1'b1;
    end
    proto_err_d = proto_err_q | violation;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      proto_err_q <= 1'b0;
    end else begin
      proto_err_q <= proto_err_d;
    end
  end

  assign proto_err = proto_err_q;
`else
  // Only the word-index bits of the latched address feed the array.
  logic addr_unused;
  assign addr_unused = ^addr_q;
  assign proto_err   = 1'b0;
`endif

endmodule
